// File: rtl/squeeze_unit_if.sv
// squeeze_unit_if: bundles the request, block-input and word-output
// handshakes of the squeeze unit. The master side is the surrounding
// datapath (controller, permutation core, digest sink); the slave side is
// the squeeze unit itself.
interface squeeze_unit_if #(
  parameter int RATE_BITS = 1088,
  parameter int LEN_W     = 16
);
  // request
  logic                 start;
  logic [LEN_W-1:0]     out_len;
  logic                 busy;
  logic                 done;
  // block input from the permutation core
  logic                 blk_valid;
  logic [RATE_BITS-1:0] blk_data;
  logic                 blk_ready;
  logic                 perm_req;
  // word output towards the digest port
  logic                 out_valid;
  logic [63:0]          out_data;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output start, out_len, blk_valid, blk_data, out_ready,
    input  busy, done, blk_ready, perm_req, out_valid, out_data, out_last
  );

  modport slave (
    input  start, out_len, blk_valid, blk_data, out_ready,
    output busy, done, blk_ready, perm_req, out_valid, out_data, out_last
  );
endinterface

// File: rtl/squeeze_unit.sv
// squeeze_unit: takes one RATE_BITS block of Keccak state and emits it as
// 64-bit words (word 0 first) under valid/ready, asking for a fresh
// permutation whenever a block runs out before the requested length.
//
// Build option: define SQUEEZE_ZEROIZE_EN to wipe the block buffer when a
// request completes and to force out_data to zero while out_valid is low.
// The block buffer is cleared on reset in both builds so that every output
// reads zero straight out of reset.
module squeeze_unit #(
  parameter int RATE_BITS = 1088,
  parameter int LEN_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  squeeze_unit_if.slave  bus
);

  localparam int WORDS = RATE_BITS / 64;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    EMIT     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        blk_buf_q [WORDS];
  logic [63:0]        blk_buf_d [WORDS];
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;

  // Registered outputs; each is computed from the next state so it lines up
  // with state_q after the edge.
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic blk_ready_q, blk_ready_d;
  logic busy_q, busy_d;
  logic perm_req_q, perm_req_d;
  logic done_q, done_d;

  // Incoming block viewed as an array of 64-bit words, word k at [k*64 +: 64].
  logic [63:0] blk_words_in [WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_split
      assign blk_words_in[gi] = bus.blk_data[gi*64 +: 64];
    end
  endgenerate

  // Next-state logic: request capture, block load, word advance and the
  // done / perm_req decision on the transfer of a block's last word.
  always_comb begin
    state_d     = state_q;
    blk_buf_d   = blk_buf_q;
    word_idx_d  = word_idx_q;
    remaining_d = remaining_q;
    out_last_d  = out_last_q;
    perm_req_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.out_len != '0) begin
            remaining_d = bus.out_len;
            state_d     = WAIT_BLK;
          end else begin
            // zero-length request completes immediately
            done_d = 1'b1;
          end
        end
      end

      WAIT_BLK: begin
        if (bus.blk_valid) begin
          blk_buf_d  = blk_words_in;
          word_idx_d = '0;
          out_last_d = (remaining_q == LEN_W'(1));
          state_d    = EMIT;
        end
      end

      EMIT: begin
        if (bus.out_ready) begin
          remaining_d = remaining_q - LEN_W'(1);
          // wrap so word_idx always addresses a real word of the buffer
          word_idx_d  = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + IDX_W'(1);
          out_last_d  = (remaining_q == LEN_W'(2));
          if (remaining_q == LEN_W'(1)) begin
            // final word wins over end-of-block: done only, no perm_req
            done_d     = 1'b1;
            out_last_d = 1'b0;
            state_d    = IDLE;
`ifdef SQUEEZE_ZEROIZE_EN
            for (int i = 0; i < WORDS; i++) begin
              blk_buf_d[i] = '0;
            end
`endif
          end else if (word_idx_q == LAST_IDX) begin
            perm_req_d = 1'b1;
            out_last_d = 1'b0;
            state_d    = WAIT_BLK;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == EMIT);
    blk_ready_d = (state_d == WAIT_BLK);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset; reset abandons any
  // partially emitted block without pulsing done or perm_req.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_idx_q  <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      blk_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      perm_req_q  <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        blk_buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      blk_ready_q <= blk_ready_d;
      busy_q      <= busy_d;
      perm_req_q  <= perm_req_d;
      done_q      <= done_d;
      for (int i = 0; i < WORDS; i++) begin
        blk_buf_q[i] <= blk_buf_d[i];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.blk_ready = blk_ready_q;
  assign bus.busy      = busy_q;
  assign bus.perm_req  = perm_req_q;
  assign bus.done      = done_q;

`ifdef SQUEEZE_ZEROIZE_EN
  assign bus.out_data = out_valid_q ? blk_buf_q[word_idx_q] : 64'd0;
`else
  assign bus.out_data = blk_buf_q[word_idx_q];
`endif

endmodule

// File: tb/tb_squeeze_unit.sv
// tb_squeeze_unit: directed and randomized requests against a
// transaction-level model: the expected word stream is the concatenation
// of the supplied blocks truncated to out_len, with perm_req after every
// exhausted non-final block and a single done after the last word.
module tb_squeeze_unit;

  localparam int RATE_BITS = 1088;
  localparam int LEN_W     = 16;
  localparam int WORDS     = RATE_BITS / 64;
  localparam int BUDGET    = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  squeeze_unit_if #(.RATE_BITS(RATE_BITS), .LEN_W(LEN_W)) sif ();

  squeeze_unit #(.RATE_BITS(RATE_BITS), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [RATE_BITS-1:0] blks [$];
  logic [RATE_BITS-1:0] blk_a;
  logic [RATE_BITS-1:0] blk_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RATE_BITS-1:0] make_pat(input logic [63:0] hi);
    logic [RATE_BITS-1:0] b;
    for (int k = 0; k < WORDS; k++) b[k*64 +: 64] = hi | 64'(k);
    return b;
  endfunction

  function automatic logic [RATE_BITS-1:0] rand_block();
    logic [RATE_BITS-1:0] b;
    for (int k = 0; k < WORDS; k++) b[k*64 +: 64] = {$urandom, $urandom};
    return b;
  endfunction

  // One complete request; blks must hold at least ceil(len/WORDS) blocks.
  task automatic run_req(input string tag, input int len, input int rdy_pct,
                         input int dmin, input int dmax,
                         input int stall_idx, input int stall_len, input int restart_cyc);
    int idx = 0;
    int bi = 0;
    int wait_cnt = 0;
    int delay;
    int stall_cnt = 0;
    int cyc = 0;
    int perms = 0;
    bit have_blk = 1'b0;
    bit exp_perm = 1'b0;
    bit finished = 1'b0;
    bit r;
    logic [RATE_BITS-1:0] cur;

    sif.start   = 1'b1;
    sif.out_len = LEN_W'(len);
    step();
    sif.start = 1'b0;
    delay = $urandom_range(dmin, dmax);

    while (!finished && cyc < BUDGET) begin
      check({tag, " busy"},      64'(sif.busy),      64'd1);
      check({tag, " done"},      64'(sif.done),      64'd0);
      check({tag, " out_valid"}, 64'(sif.out_valid), 64'(have_blk));
      check({tag, " blk_ready"}, 64'(sif.blk_ready), 64'(!have_blk));
      check({tag, " perm_req"},  64'(sif.perm_req),  64'(exp_perm));
      if (exp_perm) perms++;
      if (have_blk) begin
        cur = blks[bi];
        check({tag, " out_data"}, sif.out_data, cur[(idx % WORDS)*64 +: 64]);
        check({tag, " out_last"}, 64'(sif.out_last), 64'(idx == len - 1));
      end
      exp_perm = 1'b0;

      // out_len wanders and a stray start may appear: both must be ignored
      sif.out_len = LEN_W'($urandom);
      sif.start   = (cyc == restart_cyc);

      if (have_blk) begin
        if (idx == stall_idx && stall_cnt < stall_len) begin
          r = 1'b0;
          stall_cnt++;
        end else begin
          r = ($urandom_range(1, 100) <= rdy_pct);
        end
        sif.out_ready = r;
        sif.blk_valid = 1'($urandom_range(0, 1));
        sif.blk_data  = rand_block();
        if (r) begin
          idx++;
          if (idx == len) begin
            finished = 1'b1;
          end else if (idx % WORDS == 0) begin
            have_blk = 1'b0;
            exp_perm = 1'b1;
            bi++;
            wait_cnt = 0;
            delay = $urandom_range(dmin, dmax);
          end
        end
      end else begin
        sif.out_ready = 1'($urandom_range(0, 1));
        if (wait_cnt == delay) begin
          sif.blk_valid = 1'b1;
          sif.blk_data  = blks[bi];
          have_blk = 1'b1;
        end else begin
          sif.blk_valid = 1'b0;
          wait_cnt++;
        end
      end
      step();
      cyc++;
    end

    check({tag, " within budget"}, 64'(cyc < BUDGET), 64'd1);
    sif.start     = 1'b0;
    sif.blk_valid = 1'b0;
    sif.out_ready = 1'b0;
    check({tag, " done pulse"},   64'(sif.done),      64'd1);
    check({tag, " busy end"},     64'(sif.busy),      64'd0);
    check({tag, " valid end"},    64'(sif.out_valid), 64'd0);
    check({tag, " perm end"},     64'(sif.perm_req),  64'd0);
    check({tag, " ready end"},    64'(sif.blk_ready), 64'd0);
    check({tag, " perm count"},   64'(perms),         64'((len + WORDS - 1) / WORDS - 1));
    step();
    check({tag, " done single"},  64'(sif.done),      64'd0);
    $display("[TB] req %s len=%0d beats=%0d perm_reqs=%0d cycles=%0d", tag, len, idx, perms, cyc);
  endtask

  initial begin
    int len;
    blk_a = make_pat(64'hF0F0_0000_0000_0000);
    blk_b = make_pat(64'hB0B0_0000_0000_0000);
    sif.start     = 1'b0;
    sif.out_len   = '0;
    sif.blk_valid = 1'b0;
    sif.blk_data  = '0;
    sif.out_ready = 1'b1;

    // reset state
    repeat (3) step();
    check("rst out_valid", 64'(sif.out_valid), 64'd0);
    check("rst out_data",  sif.out_data,       64'd0);
    check("rst out_last",  64'(sif.out_last),  64'd0);
    check("rst blk_ready", 64'(sif.blk_ready), 64'd0);
    check("rst perm_req",  64'(sif.perm_req),  64'd0);
    check("rst busy",      64'(sif.busy),      64'd0);
    check("rst done",      64'(sif.done),      64'd0);
    reset = 1'b0;
    step();

    // short request inside one block
    blks = {blk_a};
    run_req("len4", 4, 100, 0, 0, -1, 0, -1);

    // spans two blocks, block B arrives 3 cycles after perm_req
    blks = {blk_a, blk_b};
    run_req("len20", 20, 100, 3, 3, -1, 0, -1);

    // backpressure on A2 for 3 cycles
    blks = {blk_a};
    run_req("stall", 6, 100, 0, 0, 2, 3, -1);

    // zero-length request
    sif.start   = 1'b1;
    sif.out_len = '0;
    step();
    sif.start = 1'b0;
    check("len0 done",      64'(sif.done),      64'd1);
    check("len0 busy",      64'(sif.busy),      64'd0);
    check("len0 out_valid", 64'(sif.out_valid), 64'd0);
    step();
    check("len0 done single", 64'(sif.done), 64'd0);
    check("len0 busy after",  64'(sif.busy), 64'd0);

    // reset during the A5 beat
    sif.start   = 1'b1;
    sif.out_len = LEN_W'(17);
    step();
    sif.start     = 1'b0;
    sif.blk_valid = 1'b1;
    sif.blk_data  = blk_a;
    step();
    sif.blk_valid = 1'b0;
    sif.out_ready = 1'b1;
    repeat (5) step();
    check("abort A5 data", sif.out_data, 64'hF0F0_0000_0000_0005);
    reset = 1'b1;
    step();
    check("abort out_valid", 64'(sif.out_valid), 64'd0);
    check("abort busy",      64'(sif.busy),      64'd0);
    check("abort done",      64'(sif.done),      64'd0);
    check("abort perm_req",  64'(sif.perm_req),  64'd0);
    check("abort out_data",  sif.out_data,       64'd0);
    reset = 1'b0;
    step();
    check("abort done after", 64'(sif.done), 64'd0);
    blks = {blk_a};
    run_req("after_abort", 2, 100, 0, 0, -1, 0, -1);

    // second start while busy is ignored
    blks = {blk_a};
    run_req("restart", 5, 100, 0, 0, -1, 0, 3);

    // exact block boundaries: final word of a block gives done only
    blks = {blk_b};
    run_req("len17", 17, 100, 0, 2, -1, 0, -1);
    blks = {blk_a, blk_b};
    run_req("len34", 34, 80, 0, 2, -1, 0, 20);

    // randomized requests
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(1, 60);
      blks = {};
      for (int b = 0; b < (len + WORDS - 1) / WORDS; b++) blks.push_back(rand_block());
      run_req($sformatf("rand%0d", t), len, $urandom_range(40, 100), 0, 4,
              $urandom_range(0, len - 1), $urandom_range(0, 3), $urandom_range(0, 30));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
